// File: rtl/serial_alu_sequencer_if.sv
// Bundle between the serial ALU sequencer, its requester and the one-bit ALU.
// The slave modport is the sequencer itself. The master modport is the surrounding logic: requester plus ALU.
interface serial_alu_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             op_m;
    logic [1:0]       op_s;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             alu_m;
    logic [1:0]       alu_s;
    logic             alu_a;
    logic             alu_b;
    logic             alu_f;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output start, op_m, op_s, a_in, b_in, alu_f,
        input  alu_m, alu_s, alu_a, alu_b, busy, done, result, zero
    );

    modport slave (
        input  start, op_m, op_s, a_in, b_in, alu_f,
        output alu_m, alu_s, alu_a, alu_b, busy, done, result, zero
    );
endinterface

// File: rtl/serial_alu_sequencer.sv
// Bit-serial operand feeder / result collector around a one-bit logic ALU.
// Operands go out LSB-first. The ALU's f bit is shifted back in MSB-side, so result[i] = f(a[i], b[i]).
module serial_alu_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    serial_alu_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_next;
    logic [CNT_W-1:0] cnt;
    logic             m_q;
    logic [1:0]       s_q;
    logic             zero_q;
    logic             accept;
    logic             last_bit;

    always_comb begin
        accept      = 1'b0;
        last_bit    = (cnt == CNT_W'(WIDTH - 1));
        result_next = {bus.alu_f, result_q[WIDTH-1:1]};
        state_next  = state;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // A start here chains straight into the next operation with no IDLE gap.
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh     <= '0;
            b_sh     <= '0;
            result_q <= '0;
            cnt      <= '0;
            m_q      <= 1'b0;
            s_q      <= 2'b00;
            zero_q   <= 1'b0;
        end else if (accept) begin
            a_sh <= bus.a_in;
            b_sh <= bus.b_in;
            m_q  <= bus.op_m;
            s_q  <= bus.op_s;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            a_sh     <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh     <= {1'b0, b_sh[WIDTH-1:1]};
            result_q <= result_next;
            cnt      <= cnt + CNT_W'(1);
            // The zero flag is taken from the completed word, so it changes together with done.
            if (last_bit) begin
                zero_q <= (result_next == '0);
            end
        end
    end

    assign bus.alu_a  = (state == SHIFT) & a_sh[0];
    assign bus.alu_b  = (state == SHIFT) & b_sh[0];
    assign bus.alu_m  = m_q;
    assign bus.alu_s  = s_q;
    assign bus.busy   = (state == SHIFT);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;
    assign bus.zero   = zero_q;
endmodule

// File: doc/serial_alu_sequencer.md
Name: serial_alu_sequencer

Overview:
- Bit-serial operand feeder and result collector that sits directly upstream and downstream of the one-bit logic ALU.
- Latches two WIDTH-bit operands and an operation code on a start request.
- Presents the operands LSB-first, one bit per clock, to the one-bit ALU's a/b inputs along with a held m/s code.
- Shifts the ALU's f output back into a WIDTH-bit result register and signals done when the word is complete.

Parameters:
- WIDTH, 4, operand/result word width in bits (legal range 2..16).
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin an operation; sampled on rising edge.
- op_m  input  1  mode bit, latched on accepted start.
- op_s  input  2  function select, latched on accepted start.
- a_in  input  WIDTH  operand A, latched on accepted start.
- b_in  input  WIDTH  operand B, latched on accepted start.
- alu_m  output  1  mode to the one-bit ALU.
- alu_s  output  2  select to the one-bit ALU.
- alu_a  output  1  current A bit to the one-bit ALU.
- alu_b  output  1  current B bit to the one-bit ALU.
- alu_f  input  1  combinational result bit from the one-bit ALU.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when result is valid.
- result  output  WIDTH  assembled result word.
- zero  output  1  high when result == 0; updated with done.

Behaviour:
- Reset: state=IDLE; a_sh, b_sh, result, bit counter = 0; alu_m=0, alu_s=0, alu_a=0, alu_b=0, busy=0, done=0, zero=0. Reset wins over start in the same cycle.
- States:
  - IDLE: start=1 → latch a_in→a_sh, b_in→b_sh, op_m, op_s; clear counter; go SHIFT.
  - SHIFT: each cycle, alu_a=a_sh[0] and alu_b=b_sh[0] (registered shifter outputs, no combinational path from a_in/b_in).
    - At the edge: result <= {alu_f, result[WIDTH-1:1]}; a_sh and b_sh shift right with zero fill; counter increments.
    - When counter reaches WIDTH-1 at that edge, go DONE.
  - DONE: done=1 for exactly one cycle; zero=(result==0); then IDLE. start=1 in DONE is accepted exactly as in IDLE (back-to-back; next state SHIFT).
- Operation code: alu_m and alu_s hold the latched op for the entire operation and remain held in IDLE until the next accepted start.
- Latency: start sampled at edge E0. SHIFT occupies the cycles after E0 through E_WIDTH. done is high in the cycle after edge E_WIDTH. Result LSB = f computed from bit 0.
- Bit order: LSB is presented first, so after WIDTH captures result[i] = f(a[i], b[i]).
- start while busy=1: ignored, with no effect on operands, op code or counter.
- result and zero hold their values after DONE until the first capture edge of the next operation.
- Reset asserted mid-SHIFT: the operation is abandoned, all state returns to its reset values, and no done is produced.
- alu_f is combinational from alu_a/alu_b/alu_m/alu_s; it is sampled at the same edge that advances the shifters.
- Bench reference function for the one-bit ALU:
  - s[1]=0: s[0]=0 → f=a; s[0]=1 → f=~a.
  - s[1]=1, {m,s[0]}: 00 → a^b; 01 → ~(a^b); 10 → a|b; 11 → ~a|b.
- The bench drives alu_f from its own model of this function, not from the existing ALU module.

Test Plan:
1. Reset held for 3 cycles, then released with start=0 → all outputs 0, busy=0, done never pulses.
2. WIDTH=4, a_in=4'b1100, b_in=4'b1010, op_m=0, op_s=2'b10 (XOR), start for 1 cycle → busy high for 4 cycles; alu_a sequence 0,0,1,1; alu_b sequence 0,1,0,1; done pulses in cycle 5; result=4'b0110, zero=0.
3. a_in=4'b1010, b_in=4'b1010, op_m=0, op_s=2'b10 → result=4'b0000, zero=1. Then start again in the DONE cycle with op_m=1, op_s=2'b10 (OR), a_in=4'b0001, b_in=4'b0100 → SHIFT follows immediately with no IDLE gap; result=4'b0101.
4. start pulsed again during cycle 2 of SHIFT with different operands → ignored; result matches the first operation only; exactly one done pulse.
5. reset asserted in cycle 3 of SHIFT → next cycle: state IDLE, result=0, busy=0; no done pulse follows.
6. op_m=0, op_s=2'b01 (NOT a), a_in=4'b0011, b_in=4'bxxxx-free random → result=4'b1100; alu_m/alu_s stay at 0/01 throughout the operation and afterwards in IDLE.
